// File: rtl/ray_dispatcher_pkg.sv
// Shared types and defaults for the primary-ray dispatcher and its raster walker.
package ray_dispatcher_pkg;

    localparam int DEFAULT_SCREEN_WIDTH     = 640;
    localparam int DEFAULT_SCREEN_HEIGHT    = 480;
    localparam int DEFAULT_X_WIDTH          = 10;
    localparam int DEFAULT_Y_WIDTH          = 10;
    localparam int DEFAULT_WATCHDOG_CYCLES  = 1048576;
    localparam int PIXEL_COUNT_WIDTH        = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } dispatch_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/ray_dispatcher_raster_walker.sv
// Raster-order pixel walker: holds the pending (x, y) and steps it on each advance.
module raster_walker
    import ray_dispatcher_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter int X_WIDTH       = DEFAULT_X_WIDTH,
    parameter int Y_WIDTH       = DEFAULT_Y_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               last
);

    localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(SCREEN_HEIGHT - 1);

    logic x_wrap;

    assign x_wrap = (x == X_MAX);
    assign last   = x_wrap && (y == Y_MAX);

    // NOTE: non-blocking assignments so x and y both update from the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_wrap) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// Frame-level primary-ray issuer: clears the core counter, issues every pixel in
// raster order under fifo_full backpressure, then waits for the core to finish.
module ray_dispatcher
    import ray_dispatcher_pkg::*;
#(
    parameter int SCREEN_WIDTH    = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT   = DEFAULT_SCREEN_HEIGHT,
    parameter int X_WIDTH         = DEFAULT_X_WIDTH,
    parameter int Y_WIDTH         = DEFAULT_Y_WIDTH,
    parameter int WATCHDOG_CYCLES = DEFAULT_WATCHDOG_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         fifo_full,
    input  logic [PIXEL_COUNT_WIDTH-1:0] pixel_counter,
    output logic                         add_input,
    output logic [X_WIDTH-1:0]           ray_x,
    output logic [Y_WIDTH-1:0]           ray_y,
    output logic                         reset_pixel_counter,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [31:0]                  frame_cycles
);

    localparam logic [PIXEL_COUNT_WIDTH-1:0] FRAME_PIXELS =
        PIXEL_COUNT_WIDTH'(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam int                WD_W    = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    dispatch_state_t              state;
    dispatch_state_t              state_next;
    logic                         start_accept;
    logic                         last_pixel;
    logic                         drain_complete;
    logic                         pc_flat;
    logic                         wd_expire;
    logic [WD_W-1:0]              wd_count;
    logic [PIXEL_COUNT_WIDTH-1:0] pc_prev;

    assign start_accept        = (state == ST_IDLE) && start && !abort;
    assign add_input           = (state == ST_ISSUE) && !fifo_full && !abort;
    assign reset_pixel_counter = (state == ST_CLEAR);
    assign busy                = (state != ST_IDLE);
    assign done                = (state == ST_DONE);

    // Overshoot counts as complete so a miscounting core cannot wedge the frame.
    assign drain_complete = (pixel_counter >= FRAME_PIXELS);
    assign pc_flat        = (pixel_counter == pc_prev);
    assign wd_expire      = (state == ST_DRAIN) && !drain_complete && pc_flat
                            && (wd_count == WD_LAST);

    raster_walker #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .X_WIDTH       (X_WIDTH),
        .Y_WIDTH       (Y_WIDTH)
    ) u_walker (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_accept),
        .advance (add_input),
        .x       (ray_x),
        .y       (ray_y),
        .last    (last_pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets its default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start_accept) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_ISSUE;
            ST_ISSUE: if (add_input && last_pixel) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_complete)  state_next = ST_DONE;
                else if (wd_expire)  state_next = ST_IDLE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error        <= 1'b0;
            frame_cycles <= '0;
            wd_count     <= '0;
            pc_prev      <= '0;
        end else begin
            pc_prev <= pixel_counter;

            if (start_accept) begin
                error        <= 1'b0;
                frame_cycles <= '0;
            end else if (state inside {ST_CLEAR, ST_ISSUE, ST_DRAIN}) begin
                frame_cycles <= sat_inc32(frame_cycles);
            end

            if (wd_expire && !abort) error <= 1'b1;

            // Watchdog only measures consecutive flat cycles while draining.
            if ((state != ST_DRAIN) || !pc_flat) wd_count <= '0;
            else                                 wd_count <= wd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher on a 4x2 screen with a 16-cycle watchdog.
module tb_ray_dispatcher;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int XW   = 2;
    localparam int YW   = 1;
    localparam int WD   = 16;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          fifo_full;
    logic [31:0]   pixel_counter = '0;
    logic          add_input;
    logic [XW-1:0] ray_x;
    logic [YW-1:0] ray_y;
    logic          reset_pixel_counter;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   frame_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    bit          pc_stuck     = 1'b0;
    logic [31:0] pc_stuck_val = '0;

    always #5 clk = ~clk;

    ray_dispatcher #(
        .SCREEN_WIDTH    (W),
        .SCREEN_HEIGHT   (H),
        .X_WIDTH         (XW),
        .Y_WIDTH         (YW),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .abort               (abort),
        .fifo_full           (fifo_full),
        .pixel_counter       (pixel_counter),
        .add_input           (add_input),
        .ray_x               (ray_x),
        .ray_y               (ray_y),
        .reset_pixel_counter (reset_pixel_counter),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .frame_cycles        (frame_cycles)
    );

    // Ray core stand-in: counts accepted rays, one cycle of latency.
    always @(posedge clk) begin
        if (pc_stuck)                 pixel_counter <= pc_stuck_val;
        else if (reset_pixel_counter) pixel_counter <= '0;
        else if (add_input)           pixel_counter <= pixel_counter + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input logic s, input logic a, input logic f);
        @(negedge clk);
        start     = s;
        abort     = a;
        fifo_full = f;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".add_input"}, 32'(add_input), 0);
        check({tag, ".ray_x"}, 32'(ray_x), 0);
        check({tag, ".ray_y"}, 32'(ray_y), 0);
        check({tag, ".rpc"}, 32'(reset_pixel_counter), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".error"}, 32'(error), 0);
        check({tag, ".frame_cycles"}, frame_cycles, 0);
    endtask

    // mode 0: no backpressure, 1: full on ISSUE cycles 3..5, 2: random backpressure
    task automatic run_frame(input int mode, input string tag);
        int n         = 0;
        int busy_cyc  = 0;
        int rpc_cnt   = 0;
        int done_cnt  = 0;
        int cyc       = 0;
        bit finished  = 1'b0;
        logic f;
        step(1'b1, 1'b0, 1'b0);
        while (!finished && cyc < 500) begin
            f = 1'b0;
            if (mode == 1) f = (cyc >= 3 && cyc <= 5);
            if (mode == 2) f = ($urandom_range(0, 2) == 0);
            step(1'b0, 1'b0, f);
            if (cyc == 0) check({tag, ".error_cleared"}, 32'(error), 0);
            if (busy && !done) busy_cyc++;
            if (reset_pixel_counter) rpc_cnt++;
            if (busy && n < NPIX) begin
                check($sformatf("%s.x[%0d]", tag, n), 32'(ray_x), 32'(n % W));
                check($sformatf("%s.y[%0d]", tag, n), 32'(ray_y), 32'(n / W));
            end
            if (cyc >= 1 && n < NPIX)
                check($sformatf("%s.issue_c%0d", tag, cyc), 32'(add_input), 32'(!f));
            if (add_input) n++;
            if (done) begin
                done_cnt++;
                check({tag, ".frame_cycles_at_done"}, frame_cycles, 32'(busy_cyc));
                finished = 1'b1;
            end else if (!busy) begin
                finished = 1'b1;
            end
            cyc++;
        end
        check({tag, ".completed"}, 32'(done_cnt), 1);
        step(1'b0, 1'b0, 1'b0);
        check({tag, ".done_one_cycle"}, 32'(done), 0);
        check({tag, ".idle_after"}, 32'(busy), 0);
        check({tag, ".issues"}, 32'(n), 32'(NPIX));
        check({tag, ".rpc_pulses"}, 32'(rpc_cnt), 1);
        check({tag, ".error_after"}, 32'(error), 0);
        if (mode == 0) check({tag, ".frame_cycles"}, frame_cycles, 32'(NPIX + 2));
        if (mode == 1) check({tag, ".frame_cycles"}, frame_cycles, 32'(NPIX + 5));
    endtask

    typedef struct {
        logic start;
        logic ff;
        logic add;
        int   x;
        int   y;
        logic rpc;
        logic busy;
        logic done;
        int   fc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int drain;
        int cyc;
        bit saw_done;

        // Cycle-by-cycle expectations for an unstalled frame; start at row 4 must be ignored.
        for (int k = 0; k < 13; k++) begin
            tbl[k].start = (k == 0 || k == 4);
            tbl[k].ff    = 1'b0;
            tbl[k].add   = (k >= 2 && k <= 9);
            tbl[k].x     = tbl[k].add ? (k - 2) % W : 0;
            tbl[k].y     = tbl[k].add ? (k - 2) / W : 0;
            tbl[k].rpc   = (k == 1);
            tbl[k].busy  = (k >= 1 && k <= 11);
            tbl[k].done  = (k == 11);
            tbl[k].fc    = (k == 0) ? 0 : ((k <= 11) ? k - 1 : 10);
        end

        reset = 1'b1; start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 13; k++) begin
            step(tbl[k].start, 1'b0, tbl[k].ff);
            check($sformatf("vec%0d.add", k), 32'(add_input), 32'(tbl[k].add));
            check($sformatf("vec%0d.x", k), 32'(ray_x), 32'(tbl[k].x));
            check($sformatf("vec%0d.y", k), 32'(ray_y), 32'(tbl[k].y));
            check($sformatf("vec%0d.rpc", k), 32'(reset_pixel_counter), 32'(tbl[k].rpc));
            check($sformatf("vec%0d.busy", k), 32'(busy), 32'(tbl[k].busy));
            check($sformatf("vec%0d.done", k), 32'(done), 32'(tbl[k].done));
            check($sformatf("vec%0d.fc", k), frame_cycles, 32'(tbl[k].fc));
        end

        run_frame(0, "plain");
        run_frame(1, "stall");
        for (int r = 0; r < 4; r++) run_frame(2, $sformatf("rand%0d", r));

        // start and abort together while idle: abort wins
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("start_abort.busy", 32'(busy), 0);
        check("start_abort.rpc", 32'(reset_pixel_counter), 0);

        // Watchdog: core stuck at 5 pixels
        pc_stuck = 1'b1; pc_stuck_val = 32'd5;
        step(1'b1, 1'b0, 1'b0);
        n = 0; drain = 0; cyc = 0; saw_done = 1'b0;
        while (cyc < 200) begin
            step(1'b0, 1'b0, 1'b0);
            if (done) saw_done = 1'b1;
            if (!busy) break;
            if (add_input) n++;
            else if (n == NPIX) drain++;
            cyc++;
        end
        check("wd.issues", 32'(n), 32'(NPIX));
        check("wd.flat_cycles", 32'(drain), 32'(WD));
        check("wd.error", 32'(error), 1);
        check("wd.busy", 32'(busy), 0);
        check("wd.no_done", 32'(saw_done), 0);
        step(1'b0, 1'b0, 1'b0);
        check("wd.error_sticky", 32'(error), 1);
        pc_stuck = 1'b0;
        run_frame(0, "post_wd");

        // Abort after three issues
        step(1'b1, 1'b0, 1'b0);
        n = 0; cyc = 0;
        while (n < 3 && cyc < 50) begin
            step(1'b0, 1'b0, 1'b0);
            if (add_input) n++;
            cyc++;
        end
        step(1'b0, 1'b1, 1'b0);
        check("abort.masked", 32'(add_input), 0);
        check("abort.busy_in_cycle", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (add_input) n++;
            check($sformatf("abort.idle%0d", i), 32'(busy), 0);
            check($sformatf("abort.no_done%0d", i), 32'(done), 0);
        end
        check("abort.issues", 32'(n), 3);
        check("abort.core_count", pixel_counter, 3);
        check("abort.error", 32'(error), 0);

        // Reset while draining
        pc_stuck = 1'b1; pc_stuck_val = '0;
        step(1'b1, 1'b0, 1'b0);
        n = 0; cyc = 0;
        while (n < NPIX && cyc < 50) begin
            step(1'b0, 1'b0, 1'b0);
            if (add_input) n++;
            cyc++;
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("drain.busy", 32'(busy), 1);
        check("drain.no_issue", 32'(add_input), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("drain_reset");
        @(negedge clk);
        reset = 1'b0;
        pc_stuck = 1'b0;
        run_frame(0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Frame-level primary-ray issuer sitting upstream of the ray core. On a start request it clears the core's pixel counter, then walks the screen in raster order and pushes one pixel coordinate per accepted cycle into the core's surface input FIFO, honouring `fifo_full` backpressure. It then waits until the core's returned `pixel_counter` reaches the frame size, and reports done, watchdog error and frame cycle count.

## Interface
Parameters:
- SCREEN_WIDTH, 640, pixels per line (≥2)
- SCREEN_HEIGHT, 480, lines per frame (≥1)
- X_WIDTH, 10, coordinate width for x (must hold SCREEN_WIDTH-1)
- Y_WIDTH, 10, coordinate width for y (must hold SCREEN_HEIGHT-1)
- WATCHDOG_CYCLES, 1048576, drain cycles allowed without pixel_counter progress

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to render a frame; ignored unless idle
- abort  in  1  stop issuing and return to idle
- fifo_full  in  1  core surface FIFO full; no issue while high
- pixel_counter  in  32  core's completed-pixel count
- add_input  out  1  issue strobe to core
- ray_x  out  X_WIDTH  pixel x of issued ray
- ray_y  out  Y_WIDTH  pixel y of issued ray
- reset_pixel_counter  out  1  clears core pixel counter
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse
- error  out  1  sticky watchdog flag, cleared by next accepted start
- frame_cycles  out  32  cycles from start accept to done

## Operation
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 → CLEAR; clear `error`, `frame_cycles`, x, y, issued count.
- CLEAR: `reset_pixel_counter`=1 for exactly this cycle → ISSUE.
- ISSUE: `add_input` = !fifo_full (combinational from registered state; only comb path). On issue, x increments; at x=SCREEN_WIDTH-1 x wraps to 0 and y increments. Issue of (W-1,H-1) → DRAIN. `ray_x/ray_y` always show the pending coordinate, stable while `fifo_full` stalls.
- DRAIN: `add_input`=0. `pixel_counter` == W*H → DONE. Watchdog counter resets whenever `pixel_counter` changes; reaching WATCHDOG_CYCLES sets `error` → IDLE, no `done`.
- DONE: `done`=1 one cycle → IDLE.
- `frame_cycles` increments every cycle in CLEAR/ISSUE/DRAIN, holds after, saturates at 2^32-1.
- `busy` = state ≠ IDLE.
- `abort` in any non-IDLE state → IDLE next cycle; no issue in the abort cycle (abort masks `add_input`), no `done`, `error` unchanged.
- `start` outside IDLE ignored; `start` and `abort` together in IDLE: abort wins.
- Issued count never exceeds W*H; `pixel_counter` > W*H in DRAIN treated as complete.

## Timing
- Reset: state IDLE; `add_input`, `reset_pixel_counter`, `busy`, `done`, `error`=0; `ray_x`, `ray_y`, `frame_cycles`=0.
- start at cycle t → CLEAR at t+1 → first possible `add_input` at t+2.
- Throughput: one ray/cycle while `fifo_full`=0; unstalled frame occupies ISSUE for exactly W*H cycles.
- `fifo_full` rising in cycle c blocks issue in c itself.
- `done` asserts the cycle after `pixel_counter` == W*H is sampled in DRAIN.
- Reset mid-frame: next cycle all outputs at reset values; no partial strobes.

## Structure
- Shared package: dispatcher state enum, SCREEN_WIDTH/SCREEN_HEIGHT defaults alongside existing render constants.
- Sub-module `raster_walker`: x/y counter with advance input, wrap, and last-pixel flag; FSM, watchdog and cycle counter stay in the top.

## Test plan
- W=4,H=2, fifo_full=0, model returns pixel_counter instantly: 8 issues (0,0)…(3,1) on consecutive cycles starting t+2; `done` one cycle; `frame_cycles` matches count.
- Same, fifo_full high for cycles 3–5 of ISSUE: coordinates held, no add_input during stall, still 8 issues, order unchanged.
- `reset_pixel_counter` exactly one pulse at t+1; `start` while busy ignored (no second pulse).
- WATCHDOG_CYCLES=16, pixel_counter stuck at 5: `error`=1 after 16 flat cycles, no `done`, `busy`=0; next start clears `error`.
- `abort` mid-ISSUE after 3 issues: no issue in abort cycle, IDLE next, total add_input count 3.
- `reset` asserted in DRAIN: all outputs zero next cycle, subsequent start renders full frame correctly.
